// File: rtl/mura_pkg.sv
// Shared definitions for the mura step arbiter slice.
// Contents:
//   mura_state_e  - arbiter FSM state encoding (3 bits)
//   MURA_N_REQ    - default requester count
//   MURA_SETTLE   - default settle interval between step and y sample
//   mura_idx_w()  - width of a requester index for a given requester count
package mura_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } mura_state_e;

  localparam int MURA_N_REQ  = 4;
  localparam int MURA_SETTLE = 2;

  // Index width; never below 1 bit so that degenerate counts still elaborate.
  function automatic int mura_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mura_step_arbiter_if.sv
// Client-side bundle of the mura step arbiter.
// Signals:
//   req    - per-requester request level, held until its gnt
//   req_a  - per-requester step input bit
//   gnt    - one-hot, one-cycle grant
//   done   - one-hot, one-cycle completion
//   y_out  - sampled automaton output, valid with done, held afterwards
//   busy   - arbiter is in any state other than IDLE
// Modports: master = client logic, slave = arbiter.
interface mura_step_arbiter_if
  import mura_pkg::*;
#(
  parameter int N_REQ = MURA_N_REQ
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_a;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             y_out;
  logic             busy;

  modport master (
    output req, req_a,
    input  gnt, done, y_out, busy
  );

  modport slave (
    input  req, req_a,
    output gnt, done, y_out, busy
  );

endinterface

// File: rtl/mura_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  N_REQ - request vector
//   last  in  IW    - index granted most recently (lowest priority)
//   any   out 1     - at least one request present
//   idx   out IW    - winner; search starts at last+1 and wraps
module mura_rr_pick
  import mura_pkg::*;
#(
  parameter int N_REQ = MURA_N_REQ,
  localparam int IW   = mura_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             any,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down to the nearest one so that the
  // candidate closest to last+1 overwrites any earlier hit.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % N_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mura_step_arbiter.sv
// Round-robin arbiter/sequencer sharing one Moore step automaton among
// N_REQ requesters. Each grant issues exactly one en-qualified step with the
// winner's input bit, waits SETTLE cycles, samples the automaton output and
// reports it back with a one-hot done.
// Ports:
//   clk      in  - rising-edge clock
//   rst_n    in  - asynchronous active-low reset
//   bus      slave modport of mura_step_arbiter_if (req/req_a/gnt/done/y_out/busy)
//   step_en  out - automaton en, high only in ISSUE
//   step_a   out - automaton a, valid only in ISSUE (0 otherwise)
//   mura_y   in  - automaton y
// All outputs come straight from registers; nothing combinational from req.
module mura_step_arbiter
  import mura_pkg::*;
#(
  parameter int N_REQ  = MURA_N_REQ,
  parameter int SETTLE = MURA_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mura_step_arbiter_if.slave   bus,
  output logic                 step_en,
  output logic                 step_a,
  input  logic                 mura_y
);

  localparam int IW = mura_idx_w(N_REQ);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
      $error("mura_step_arbiter: SETTLE must be in 1..15");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_range
      $error("mura_step_arbiter: N_REQ must be in 2..8");
    end
  endgenerate

  mura_state_e      state_reg;
  logic [IW-1:0]    idx_reg;
  logic [IW-1:0]    last_reg;
  logic             a_q_reg;
  logic [3:0]       cnt_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] done_reg;
  logic             y_out_reg;
  logic             busy_reg;
  logic             step_en_reg;
  logic             step_a_reg;

  logic             pick_any;
  logic [IW-1:0]    pick_idx;

  // Single picker serves both IDLE and REPORT; in REPORT last already holds
  // the finishing requester, which makes it lowest priority.
  mura_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      last_reg    <= IW'(N_REQ - 1);
      a_q_reg     <= 1'b0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      y_out_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      step_en_reg <= 1'b0;
      step_a_reg  <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that owns them re-asserts.
      gnt_reg     <= '0;
      done_reg    <= '0;
      step_en_reg <= 1'b0;
      step_a_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_REPORT: begin
          if (pick_any) begin
            idx_reg   <= pick_idx;
            a_q_reg   <= bus.req_a[pick_idx];
            gnt_reg   <= onehot(pick_idx);
            busy_reg  <= 1'b1;
            state_reg <= ST_GRANT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          last_reg    <= idx_reg;
          step_en_reg <= 1'b1;
          step_a_reg  <= a_q_reg;
          state_reg   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // The automaton steps on this edge; count the settle cycles after it.
          cnt_reg   <= 4'(SETTLE - 1);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            y_out_reg <= mura_y;
            done_reg  <= onehot(idx_reg);
            state_reg <= ST_REPORT;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.done  = done_reg;
  assign bus.y_out = y_out_reg;
  assign bus.busy  = busy_reg;
  assign step_en   = step_en_reg;
  assign step_a    = step_a_reg;

endmodule

// File: tb/tb_mura_step_arbiter.sv
// Self-checking bench for mura_step_arbiter. Three instances share clock and
// reset: SETTLE=2 (main), SETTLE=1 and SETTLE=15. Each drives a small
// mod-3 step automaton (y=1 in states 1 and 2, advances when en && a).
module tb_mura_step_arbiter;
  import mura_pkg::*;

  localparam int N = MURA_N_REQ;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mura_step_arbiter_if #(.N_REQ(N)) bus0 ();
  mura_step_arbiter_if #(.N_REQ(N)) bus1 ();
  mura_step_arbiter_if #(.N_REQ(N)) bus2 ();

  logic [N-1:0] req_v   [3];
  logic [N-1:0] req_a_v [3];
  wire  [N-1:0] gnt_w   [3];
  wire  [N-1:0] done_w  [3];
  wire  [2:0]   y_w, busy_w, en_w, sa_w, my;

  assign bus0.req = req_v[0];  assign bus0.req_a = req_a_v[0];
  assign bus1.req = req_v[1];  assign bus1.req_a = req_a_v[1];
  assign bus2.req = req_v[2];  assign bus2.req_a = req_a_v[2];
  assign gnt_w[0] = bus0.gnt;  assign done_w[0] = bus0.done;
  assign gnt_w[1] = bus1.gnt;  assign done_w[1] = bus1.done;
  assign gnt_w[2] = bus2.gnt;  assign done_w[2] = bus2.done;
  assign y_w    = {bus2.y_out, bus1.y_out, bus0.y_out};
  assign busy_w = {bus2.busy, bus1.busy, bus0.busy};

  mura_step_arbiter #(.N_REQ(N), .SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .step_en(en_w[0]), .step_a(sa_w[0]), .mura_y(my[0]));
  mura_step_arbiter #(.N_REQ(N), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .step_en(en_w[1]), .step_a(sa_w[1]), .mura_y(my[1]));
  mura_step_arbiter #(.N_REQ(N), .SETTLE(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .step_en(en_w[2]), .step_a(sa_w[2]), .mura_y(my[2]));

  // Reference automaton per instance.
  logic [1:0] ms [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) ms[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (en_w[i] && sa_w[i]) ms[i] <= (ms[i] == 2'd2) ? 2'd0 : ms[i] + 2'd1;
    end
  end
  assign my[0] = (ms[0] != 2'd0);
  assign my[1] = (ms[1] != 2'd0);
  assign my[2] = (ms[2] != 2'd0);

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] req_a;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         y;
    logic         busy;
    logic         en;
    logic         sa;
  } vec_t;
  vec_t tbl [8];

  // Event logs filled by run().
  int gq[$];
  int dq[$];
  int dcyc[$];
  bit dy[$];
  int en_cnt;
  int idle_gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_v[d]   = '0;
      req_a_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Watch instance d until `target` completions, one negedge per cycle.
  // Cycle 0 is the cycle in which the request was first driven. Requesters
  // not in `hold` drop req on seeing their own gnt.
  task automatic run(input int d, input logic [N-1:0] hold, input int target, input int budget);
    int n;
    n = -1;
    gq.delete(); dq.delete(); dcyc.delete(); dy.delete();
    en_cnt = 0;
    idle_gap = 0;
    while (dq.size() < target) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL run_timeout dut%0d: got %0d completions, expected %0d", d, dq.size(), target);
        break;
      end
      if (en_w[d]) en_cnt++;
      if (gq.size() > 0 && !busy_w[d]) idle_gap++;
      for (int k = 0; k < N; k++) begin
        if (gnt_w[d][k]) begin
          gq.push_back(k);
          if (!hold[k]) req_v[d][k] = 1'b0;
        end
        if (done_w[d][k]) begin
          dq.push_back(k);
          dcyc.push_back(n);
          dy.push_back(y_w[d]);
          $display("txn dut%0d requester=%0d y_out=%0b done_cycle=%0d", d, k, y_w[d], n);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cr [4];
    bit ca [4];
    bit cy [4];
    int nd;

    //            req      req_a    gnt      done     y     busy  en    sa
    tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state of all three instances, sampled while rst_n is low.
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_v[d]   = '0;
      req_a_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {gnt_w[0], gnt_w[1], gnt_w[2], done_w[0], done_w[1], done_w[2], y_w, busy_w, en_w, sa_w}, 32'd0);

    // Single step, cycle by cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_v[0]   = tbl[i].req;
      req_a_v[0] = tbl[i].req_a;
      @(negedge clk);
      chk($sformatf("single_step_vec%0d", i),
          {gnt_w[0], done_w[0], y_w[0], busy_w[0], en_w[0], sa_w[0]},
          {tbl[i].gnt, tbl[i].done, tbl[i].y, tbl[i].busy, tbl[i].en, tbl[i].sa});
      @(posedge clk);
      #1;
    end

    // Counting sequence: requesters 2,1,3 with a=1, then 0 with a=0.
    do_reset();
    cr = '{2, 1, 3, 0};
    ca = '{1'b1, 1'b1, 1'b1, 1'b0};
    cy = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req_v[0][cr[i]]   = 1'b1;
      req_a_v[0][cr[i]] = ca[i];
      run(0, 4'b0000, 1, 30);
      chk($sformatf("count%0d_requester", i), dq[0], cr[i]);
      chk($sformatf("count%0d_y", i), 32'(dy[0]), 32'(cy[i]));
      chk($sformatf("count%0d_latency", i), dcyc[0], 5);
    end
    chk("count_state_unchanged", 32'(ms[0]), 32'd0);

    // Full contention from reset.
    do_reset();
    req_v[0]   = 4'b1111;
    req_a_v[0] = 4'b1011;
    run(0, 4'b0000, 4, 40);
    cy = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend_gnt%0d", i), gq[i], i);
      chk($sformatf("contend_done%0d", i), dq[i], i);
      chk($sformatf("contend_done_cycle%0d", i), dcyc[i], 5 * (i + 1));
      chk($sformatf("contend_y%0d", i), 32'(dy[i]), 32'(cy[i]));
    end
    chk("contend_no_idle", idle_gap, 0);
    @(posedge clk);
    #1;
    req_v[0][0] = 1'b1;
    run(0, 4'b0000, 1, 30);
    chk("contend_regrant0", gq[0], 0);

    // Fairness: requester 1 held continuously against 2 and 3.
    do_reset();
    req_v[0] = 4'b1110;
    run(0, 4'b0010, 4, 40);
    req_v[0] = '0;
    chk("fair_gnt0", gq[0], 1);
    chk("fair_gnt1", gq[1], 2);
    chk("fair_gnt2", gq[2], 3);
    chk("fair_gnt3", gq[3], 1);
    repeat (3) @(posedge clk);

    // Reset in the first WAIT cycle.
    do_reset();
    req_v[0]   = 4'b0001;
    req_a_v[0] = 4'b0001;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) req_v[0] = '0;
    end
    chk("midrst_in_wait", {busy_w[0], en_w[0]}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs_zero",
        {gnt_w[0], done_w[0], y_w[0], busy_w[0], en_w[0], sa_w[0]}, 32'd0);
    #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (|done_w[0]) nd++;
    end
    chk("midrst_no_done", nd, 0);
    @(posedge clk);
    #1;
    req_v[0] = 4'b1001;
    run(0, 4'b0000, 2, 30);
    chk("midrst_first_gnt", gq[0], 0);
    chk("midrst_second_gnt", gq[1], 3);

    // Settle bounds.
    do_reset();
    req_v[1]   = 4'b0001;
    req_a_v[1] = 4'b0001;
    run(1, 4'b0000, 1, 30);
    chk("settle1_done_cycle", dcyc[0], 4);
    chk("settle1_step_en_cycles", en_cnt, 1);
    chk("settle1_y", 32'(dy[0]), 32'd1);
    @(posedge clk);
    #1;
    req_v[2]   = 4'b0100;
    req_a_v[2] = 4'b0100;
    run(2, 4'b0000, 1, 40);
    chk("settle15_done_cycle", dcyc[0], 18);
    chk("settle15_step_en_cycles", en_cnt, 1);
    chk("settle15_requester", dq[0], 2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
